// File: rtl/aie_noc_pkg.sv
// rtl/aie_noc_pkg.sv - shared types and defaults for the mini-AIE NoC ring arbiter
package aie_noc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int NOC_DATA_WIDTH = 8;
  localparam int NOC_NUM_REQ    = 4;
  localparam int STAT_WIDTH     = 8;

endpackage

// File: rtl/noc_ring_arbiter_rr_pick.sv
// rtl/noc_ring_arbiter_rr_pick.sv - combinational round-robin picker (module rr_pick)
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] start,
  input  logic [NUM_REQ-1:0]         exclude,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] cand;

  // Search begins one past start and wraps, so start itself is checked last.
  always_comb begin
    int idx;
    cand   = req & ~exclude;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && cand[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_ring_arbiter.sv
// rtl/noc_ring_arbiter.sv - round-robin burst arbiter onto one ring-FIFO write port
// Optional per-requester grant statistics: NOC_ARB_STATS_EN
module noc_ring_arbiter
  import aie_noc_pkg::*;
#(
  parameter int NUM_REQ    = NOC_NUM_REQ,
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  input  logic                          fifo_full,
`ifdef NOC_ARB_STATS_EN
  input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
  output logic [STAT_WIDTH-1:0]         stat_cnt,
`endif
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   beat_cnt;

  logic [IDX_W-1:0]   cur_idx;
  logic               cur_req;
  logic               cur_last;
  logic               beat_limit;
  logic               burst_release;
  logic               burst_abandon;
  logic               end_burst;

  logic [IDX_W-1:0]   pick_start;
  logic [NUM_REQ-1:0] pick_exclude;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_winner;
  logic [NUM_REQ-1:0] pick_onehot;

  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) cur_idx = IDX_W'(i);
    end
  end

  assign cur_req    = |(gnt & req);
  assign cur_last   = |(gnt & last);
  assign ack        = gnt & req & {NUM_REQ{~fifo_full}};
  assign fifo_wr_en = |ack;

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) fifo_data = data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign beat_limit    = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign burst_release = (state == BURST) && fifo_wr_en && (cur_last || beat_limit);
  assign burst_abandon = (state == BURST) && !cur_req;
  assign end_burst     = burst_release || burst_abandon;

  // During a burst the picker looks past the current owner and skips it,
  // so a releasing requester cannot win the back-to-back regrant.
  assign pick_start   = (state == BURST) ? cur_idx : rr_ptr;
  assign pick_exclude = (state == BURST) ? gnt : '0;
  assign pick_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_winner;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req     (req),
    .start   (pick_start),
    .exclude (pick_exclude),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= BURST;
            gnt      <= pick_onehot;
            busy     <= 1'b1;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (end_burst) begin
            rr_ptr   <= cur_idx;
            beat_cnt <= '0;
            if (pick_valid) begin
              gnt <= pick_onehot;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end else if (fifo_wr_en) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NOC_ARB_STATS_EN
  logic                  grant_edge;
  logic [STAT_WIDTH-1:0] stat_q [NUM_REQ];

  assign grant_edge = pick_valid && ((state == IDLE) || end_burst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (grant_edge && (stat_q[pick_winner] != {STAT_WIDTH{1'b1}})) begin
      stat_q[pick_winner] <= stat_q[pick_winner] + STAT_WIDTH'(1);
    end
  end

  assign stat_cnt = (int'(stat_sel) < NUM_REQ) ? stat_q[stat_sel] : '0;
`endif

endmodule

// File: doc/noc_ring_arbiter.md
Name: noc_ring_arbiter

Overview:
Round-robin burst arbiter that shares one ring-FIFO write port among NUM_REQ requesters (switches or compute tiles) on the mini-AIE NoC ring. A grant is held for a whole burst, until the requester's last beat or MAX_BURST beats, and honours FIFO backpressure. It sits between the per-tile switch outputs and the write side of the downstream synchronous_fifo.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, beat width in bits
MAX_BURST, 4, maximum beats per grant before forced release (1..16)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request; level, held while data is valid
last  input  NUM_REQ  per-requester final beat of the burst
data  input  NUM_REQ*DATA_WIDTH  requester i's data in bits [i*DATA_WIDTH +: DATA_WIDTH]
fifo_full  input  1  downstream FIFO full
gnt  output  NUM_REQ  registered one-hot grant
ack  output  NUM_REQ  beat accepted this cycle (combinational)
fifo_wr_en  output  1  write strobe to FIFO (combinational)
fifo_data  output  DATA_WIDTH  muxed data of granted requester
busy  output  1  registered; high in state BURST

Behaviour:
- Reset, asynchronous on rst_n low:
  - gnt=0, busy=0, state=IDLE, rr_ptr=NUM_REQ-1, beat_cnt=0.
  - ack, fifo_wr_en and fifo_data are therefore 0.
  - Reset mid-burst drops the burst. No partial-state recovery.
- States: IDLE, BURST.
- IDLE with any req high: pick the winner with rr_pick, searching from rr_ptr+1 upward with wrap.
  - Next edge: gnt=onehot(winner), state=BURST, beat_cnt=0.
  - Grant latency is 1 cycle from req.
- Beat acceptance:
  - ack[i] = gnt[i] & req[i] & ~fifo_full.
  - fifo_wr_en = |ack.
  - fifo_data = data of the granted requester when fifo_wr_en=1, else 0.
- BURST, per cycle:
  - Accepted beat without release: beat_cnt increments.
  - Release when an accepted beat has last[w]=1 or beat_cnt==MAX_BURST-1.
  - Abandon when req[w]=0 (no beat that cycle).
  - On release or abandon: rr_ptr=w. If another req is pending that cycle, excluding req[w], regrant on the same edge with no bubble, searching from w+1. Otherwise go to IDLE and clear gnt.
  - The released requester can be regranted only after a cycle in IDLE or when it is the sole requester. In that case it re-enters IDLE first, which costs 1 bubble.
- fifo_full high: no ack and no beat_cnt change. The grant is held indefinitely; there is no timeout.
- last asserted with req low is ignored.
- Grant ownership never changes without a release or abandon event.
- Arithmetic: beat_cnt has width $clog2(MAX_BURST)+1 and never wraps. rr_ptr wraps modulo NUM_REQ.

Optional Feature:
NOC_ARB_STATS_EN
- Defined:
  - Adds input stat_sel [$clog2(NUM_REQ)-1:0] and output stat_cnt [7:0].
  - Per-requester 8-bit counter of granted bursts, incremented on each grant edge. It saturates at 255 and clears on reset.
  - stat_cnt = counter[stat_sel], combinational.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical either way.

Decomposition:
- Package aie_noc_pkg holds:
  - state typedef (IDLE, BURST)
  - default NOC_DATA_WIDTH=8 and NOC_NUM_REQ=4
  - STAT_WIDTH=8
- Sub-module rr_pick: purely combinational. Inputs are the req vector, start pointer and exclude mask. Outputs are valid and winner index.
- State, counters and muxing stay in noc_ring_arbiter.

Test Plan:
- Reset, then req=4'b0101 with all last=1 and fifo_full=0 -> gnt=0001 one cycle later. One beat, data 0x11, is written; then gnt=0100 on the same edge with no bubble, data 0x33 written; then IDLE.
- req[1] held, last never asserted, MAX_BURST=4 -> exactly 4 fifo_wr_en pulses. Forced release, 1 IDLE bubble, then regrant to 1.
- All req high, all bursts of 2 beats -> grant order 0,1,2,3,0. 8 writes per round, no requester starved.
- Requester 2 granted, fifo_full=1 for 5 cycles mid-burst -> ack=0 and gnt steady through the stall. The beat count resumes at the same value; total beats equal the burst length.
- req[3] dropped after 1 beat without last -> abandon. The next pending requester is granted the same edge; the write count shows only 1 beat from 3.
- rst_n pulsed low mid-burst (async, between edges) -> gnt, busy and fifo_wr_en go 0 immediately. With NOC_ARB_STATS_EN, 300 grants to requester 0 give stat_cnt=255.
